sp_arbiter_wconv_gen: RTL



---
 rtl/sp_arbiter_wconv_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sp_arbiter_wconv_gen.sv
// Single-port memory arbiter between the PHY datapath and CBUS, with 32-bit CBUS beat width conversion.
// Optional starvation guard compiled in with SP_ARB_WCONV_STARVE_GUARD_EN.
module sp_arbiter_wconv_gen #(
  parameter int DW         = 64,
  parameter int AW         = 8,
  parameter int NBEATS     = (DW + 31) / 32,
  parameter int BEAT_AW    = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  parameter int CBUS_AW    = AW + BEAT_AW,
  parameter int MEM_RD_LAT = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic               cbus_req,
  input  logic               cbus_slv_cmd,
  input  logic [CBUS_AW-1:0] cbus_slv_address,
  input  logic [31:0]        cbus_slv_wdata,
  output logic               cbus_waccept,
  output logic               cbus_rresp,
  output logic [31:0]        cbus_rddata,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               wr_en,
  input  logic [DW-1:0]      wr_mask,
  input  logic               en,
  output logic               phy_stall,
  output logic [DW-1:0]      rd_data,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wr_data,
  output logic               mem_wr_en,
  output logic [DW-1:0]      mem_wr_mask,
  output logic               mem_en,
  input  logic [DW-1:0]      mem_rd_data
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] GRANT_WAIT = 2'd1;
  localparam logic [1:0] RD_WAIT    = 2'd2;
  localparam logic [1:0] RESP       = 2'd3;

  localparam int STG_N  = (NBEATS > 1) ? NBEATS - 1 : 1;
  localparam int LAST_W = DW - 32 * (NBEATS - 1);
  localparam logic [BEAT_AW-1:0] LAST_BEAT = BEAT_AW'(NBEATS - 1);

  logic [1:0]         state_reg, state_next;
  logic               cmd_reg;
  logic [AW-1:0]      word_reg;
  logic [BEAT_AW-1:0] beat_reg;
  logic [LAST_W-1:0]  wdata_reg;
  logic [1:0]         rd_cnt_reg;
  logic [DW-1:0]      shadow_reg;
  logic [31:0]        staging_reg [STG_N];

  logic [AW-1:0]      req_word;
  logic [BEAT_AW-1:0] req_beat;
  logic               sample;
  logic               in_grant_wait;
  logic               cbus_grant;
  logic               phy_grant;
  logic               rd_capture;
  logic [DW-1:0]      commit_word;
  logic [31:0]        beat_word [NBEATS];
  logic [31:0]        rd_beat;

  assign req_word      = cbus_slv_address[CBUS_AW-1:BEAT_AW];
  assign req_beat      = cbus_slv_address[BEAT_AW-1:0];
  assign sample        = (state_reg == IDLE) && cbus_req;
  assign in_grant_wait = (state_reg == GRANT_WAIT);
  assign rd_capture    = (state_reg == RD_WAIT) && (rd_cnt_reg == 2'(MEM_RD_LAT));
  assign phy_grant     = en && !cbus_grant;

`ifdef SP_ARB_WCONV_STARVE_GUARD_EN
  logic [7:0] starve_cnt_reg;
  logic       starve_hit;

  assign starve_hit = (starve_cnt_reg == 8'(STARVE_MAX));
  assign cbus_grant = in_grant_wait && (!en || starve_hit);
  assign phy_stall  = !sreset && in_grant_wait && en && starve_hit;

  // Counts only GRANT_WAIT cycles lost to the PHY; any CBUS grant restarts the window.
  always_ff @(posedge clk) begin
    if (sreset) begin
      starve_cnt_reg <= '0;
    end else if (cbus_grant) begin
      starve_cnt_reg <= '0;
    end else if (in_grant_wait && en) begin
      starve_cnt_reg <= starve_cnt_reg + 8'd1;
    end
  end
`else
  assign cbus_grant = in_grant_wait && !en;
  assign phy_stall  = 1'b0;
`endif

  // Beat slicing of the wide word; a partial top beat is truncated on write and zero-padded on read.
  generate
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
      localparam int LO = 32 * gi;
      localparam int W  = ((DW - LO) >= 32) ? 32 : (DW - LO);
      if (gi == NBEATS - 1) begin : g_last
        assign commit_word[LO +: W] = wdata_reg[W-1:0];
      end else begin : g_stage
        assign commit_word[LO +: W] = staging_reg[gi][W-1:0];
      end
      assign beat_word[gi] = 32'(shadow_reg[LO +: W]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cbus_req) begin
          if (cbus_slv_cmd) begin
            state_next = (req_beat == LAST_BEAT) ? GRANT_WAIT : RESP;
          end else begin
            state_next = (req_beat == '0) ? GRANT_WAIT : RESP;
          end
        end
      end
      GRANT_WAIT: begin
        if (cbus_grant) begin
          state_next = cmd_reg ? RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_capture) begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_reg  <= IDLE;
      cmd_reg    <= 1'b0;
      word_reg   <= '0;
      beat_reg   <= '0;
      wdata_reg  <= '0;
      rd_cnt_reg <= '0;
      shadow_reg <= '0;
      for (int i = 0; i < STG_N; i++) begin
        staging_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (sample) begin
        cmd_reg   <= cbus_slv_cmd;
        word_reg  <= req_word;
        beat_reg  <= req_beat;
        wdata_reg <= cbus_slv_wdata[LAST_W-1:0];
        for (int i = 0; i < NBEATS - 1; i++) begin
          if (cbus_slv_cmd && (req_beat == BEAT_AW'(i))) begin
            staging_reg[i] <= cbus_slv_wdata;
          end
        end
      end
      // Counts cycles since the read was issued; capture happens when it reaches the latency.
      if (cbus_grant) begin
        rd_cnt_reg <= 2'd1;
      end else if (state_reg == RD_WAIT) begin
        rd_cnt_reg <= rd_cnt_reg + 2'd1;
      end
      if (rd_capture) begin
        shadow_reg <= mem_rd_data;
      end
    end
  end

  always_comb begin
    rd_beat = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat_reg == BEAT_AW'(i)) begin
        rd_beat = beat_word[i];
      end
    end
  end

  assign cbus_waccept = !sreset && (state_reg == RESP) && cmd_reg;
  assign cbus_rresp   = !sreset && (state_reg == RESP) && !cmd_reg;
  assign cbus_rddata  = cbus_rresp ? rd_beat : 32'h0;
  assign rd_data      = mem_rd_data;

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    mem_wr_mask = '0;
    mem_en      = 1'b0;
    if (!sreset) begin
      if (cbus_grant) begin
        mem_en    = 1'b1;
        mem_addr  = word_reg;
        mem_wr_en = cmd_reg;
        if (cmd_reg) begin
          mem_wr_data = commit_word;
          mem_wr_mask = '1;
        end
      end else if (phy_grant) begin
        mem_en      = 1'b1;
        mem_addr    = addr;
        mem_wr_en   = wr_en;
        mem_wr_data = wr_data;
        mem_wr_mask = wr_mask;
      end
    end
  end

endmodule
